// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state type and released-level helper for the button counter bank.
// Contents:
//   btn_state_t     - 2-bit per-channel debounce FSM state
//   released_level  - pin level that means "not pressed" for a given ACTIVE_LOW setting
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    function automatic logic released_level(input int active_low);
        return active_low != 0;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button channel - synchronizer, debounce FSM, optional auto-repeat, counter.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   pin          - raw asynchronous button pin
//   clear        - synchronous count clear (an increment in the same cycle yields 1)
//   value        - WIDTH-bit press count
//   pressed      - debounced pressed level
//   press_pulse  - one-cycle strobe per accepted increment
// Optional feature: define BTN_AUTOREPEAT_EN to add auto-repeat while held.
module btn_channel
    import btn_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 5000000,
    parameter int ACTIVE_LOW      = 1,
    parameter int SATURATE        = 0,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pin,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             pressed,
    output logic             press_pulse
);

    localparam int             TW    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0]  T_END = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic           REL   = released_level(ACTIVE_LOW);
    localparam logic [WIDTH-1:0] MAX = '1;

    logic [1:0]    sync;
    logic          prs_raw;
    btn_state_t    state;
    logic [TW-1:0] timer;
    logic          acc;
    logic          inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= {2{REL}};
        else     sync <= {sync[0], pin};
    end

    assign prs_raw = sync[1] ^ REL;
    assign acc     = (state == PRESS_WAIT) && prs_raw && (timer == T_END);

`ifdef BTN_AUTOREPEAT_EN
    localparam int            RW       = $clog2(REPEAT_DELAY);
    localparam logic [RW-1:0] R_END    = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
    logic [RW-1:0] rpt;
    logic          rpt_fire;
    assign rpt_fire = (state == HELD) && prs_raw && (rpt == R_END);
    assign inc      = acc | rpt_fire;
    // Counts only while steadily held; a RELEASE_WAIT bounce freezes it, a real release clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rpt <= '0;
        else if (state == IDLE || state == PRESS_WAIT)
            rpt <= '0;
        else if (state == HELD && prs_raw)
            rpt <= rpt_fire ? R_RELOAD : rpt + 1'b1;
    end
`else
    assign inc = acc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            pressed     <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= inc;
            case (state)
                IDLE: begin
                    if (prs_raw) begin
                        state <= PRESS_WAIT;
                        timer <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!prs_raw) begin
                        state <= IDLE;
                    end else if (timer == T_END) begin
                        state   <= HELD;
                        pressed <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                HELD: begin
                    if (!prs_raw) begin
                        state <= RELEASE_WAIT;
                        timer <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (prs_raw) begin
                        state <= HELD;
                    end else if (timer == T_END) begin
                        state   <= IDLE;
                        pressed <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clear wins over the old count but keeps a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= '0;
        else if (clear)
            value <= {{(WIDTH-1){1'b0}}, inc};
        else if (inc && !(SATURATE != 0 && value == MAX))
            value <= value + 1'b1;
    end

endmodule

// File: rtl/button_counter_bank.sv
// button_counter_bank: N_CHANNELS independent debounced button press counters.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   button_pin   - raw asynchronous pins, one per channel
//   clear        - per-channel synchronous count clear
//   value        - channel i count at [i*WIDTH +: WIDTH]
//   pressed      - per-channel debounced pressed level
//   press_pulse  - per-channel one-cycle increment strobe
// Optional feature: define BTN_AUTOREPEAT_EN to enable auto-repeat while held.
module button_counter_bank
    import btn_pkg::*;
#(
    parameter int N_CHANNELS      = 4,
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 5000000,
    parameter int ACTIVE_LOW      = 1,
    parameter int SATURATE        = 0,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CHANNELS-1:0]       button_pin,
    input  logic [N_CHANNELS-1:0]       clear,
    output logic [N_CHANNELS*WIDTH-1:0] value,
    output logic [N_CHANNELS-1:0]       pressed,
    output logic [N_CHANNELS-1:0]       press_pulse
);

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
        btn_channel #(
            .WIDTH          (WIDTH),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW),
            .SATURATE       (SATURATE),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .pin        (button_pin[g]),
            .clear      (clear[g]),
            .value      (value[g*WIDTH +: WIDTH]),
            .pressed    (pressed[g]),
            .press_pulse(press_pulse[g])
        );
    end

endmodule
